go_delay_array: RTL and testbench

Parametrised array of independent go/kill delay timers with a shared, sticky kill latch and per-channel kill-source capture. Each channel starts on `go`, counts a fixed number of cycles, pulses `done`, and returns to idle; any `kill` aborts its channel and sets the shared latch. It is the multi-channel successor to the fixed three-channel go-delay wrapper, adding configurable channel count, counter width and terminal count, optional retrigger, and optional start-gating while killed.

---
 rtl/go_delay_array.sv | 123 ++++++++++++
 tb/tb_go_delay_array.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/go_delay_array.sv
// rtl/go_delay_array.sv - array of independent go/kill delay timers with shared sticky kill latch
module go_delay_array #(
    parameter int N_CH         = 3,
    parameter int CNT_W        = 7,
    parameter int TERMINAL     = 100,
    parameter int RETRIG       = 0,
    parameter int GATE_ON_KILL = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         go,
    input  logic [N_CH-1:0]         kill,
    input  logic                    kill_clr,
    output logic [N_CH-1:0]         done,
    output logic [N_CH-1:0]         busy,
    output logic [N_CH*CNT_W-1:0]   count,
    output logic                    kill_ltchd,
    output logic [N_CH-1:0]         kill_src
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TERMINAL);
    localparam logic [CNT_W-1:0] LAST_RUN = CNT_W'(TERMINAL - 1);

    logic [1:0]       state_q [N_CH];
    logic [1:0]       state_d [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];
    logic [N_CH-1:0]  done_q, done_d;
    logic             kill_ltchd_q, kill_ltchd_d;
    logic [N_CH-1:0]  kill_src_q, kill_src_d;
    logic             gated;

    // Per-channel next state: kill wins over start/retrigger, retrigger wins over terminal count
    always_comb begin
        gated = (GATE_ON_KILL != 0) && kill_ltchd_q;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            done_d[i]  = 1'b0;
            if (kill[i]) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        cnt_d[i] = '0;
                        if (go[i] && !gated) begin
                            state_d[i] = ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if ((RETRIG != 0) && go[i] && !gated) begin
                            cnt_d[i] = '0;
                        end else if (cnt_q[i] == LAST_RUN) begin
                            state_d[i] = ST_DONE;
                            cnt_d[i]   = TERM_CNT;
                            done_d[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Shared latch: any kill sets and accumulates, clear only acts on kill-free cycles
    always_comb begin
        kill_ltchd_d = kill_ltchd_q;
        kill_src_d   = kill_src_q;
        if (|kill) begin
            kill_ltchd_d = 1'b1;
            kill_src_d   = kill_src_q | kill;
        end else if (kill_clr) begin
            kill_ltchd_d = 1'b0;
            kill_src_d   = '0;
        end
    end

    // State, counter, done and latch registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            done_q       <= '0;
            kill_ltchd_q <= 1'b0;
            kill_src_q   <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            done_q       <= done_d;
            kill_ltchd_q <= kill_ltchd_d;
            kill_src_q   <= kill_src_d;
        end
    end

    // Output decode from registered state
    always_comb begin
        busy  = '0;
        count = '0;
        for (int i = 0; i < N_CH; i++) begin
            busy[i]                  = (state_q[i] != ST_IDLE);
            count[i*CNT_W +: CNT_W]  = cnt_q[i];
        end
    end

    assign done       = done_q;
    assign kill_ltchd = kill_ltchd_q;
    assign kill_src   = kill_src_q;

endmodule

// File: tb/tb_go_delay_array.sv
// tb/tb_go_delay_array.sv - scoreboard bench for go_delay_array across four parameter sets
module tb_go_delay_array;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  go_a = '0, kill_a = '0, go_b = '0, kill_b = '0, go_c = '0, kill_c = '0;
    logic [7:0]  go_d = '0, kill_d = '0;
    logic        clr_a = 1'b0, clr_b = 1'b0, clr_c = 1'b0, clr_d = 1'b0;
    logic [2:0]  done_a, busy_a, src_a, done_b, busy_b, src_b, done_c, busy_c, src_c;
    logic [7:0]  done_d, busy_d, src_d;
    logic [20:0] count_a, count_b;
    logic [5:0]  count_c;
    logic [31:0] count_d;
    logic        lt_a, lt_b, lt_c, lt_d;

    go_delay_array #(.N_CH(3), .CNT_W(7), .TERMINAL(100), .RETRIG(0), .GATE_ON_KILL(1)) u_a (
        .clk(clk), .reset(reset), .go(go_a), .kill(kill_a), .kill_clr(clr_a), .done(done_a),
        .busy(busy_a), .count(count_a), .kill_ltchd(lt_a), .kill_src(src_a));
    go_delay_array #(.N_CH(3), .CNT_W(7), .TERMINAL(100), .RETRIG(1), .GATE_ON_KILL(1)) u_b (
        .clk(clk), .reset(reset), .go(go_b), .kill(kill_b), .kill_clr(clr_b), .done(done_b),
        .busy(busy_b), .count(count_b), .kill_ltchd(lt_b), .kill_src(src_b));
    go_delay_array #(.N_CH(3), .CNT_W(2), .TERMINAL(1), .RETRIG(0), .GATE_ON_KILL(1)) u_c (
        .clk(clk), .reset(reset), .go(go_c), .kill(kill_c), .kill_clr(clr_c), .done(done_c),
        .busy(busy_c), .count(count_c), .kill_ltchd(lt_c), .kill_src(src_c));
    go_delay_array #(.N_CH(8), .CNT_W(4), .TERMINAL(15), .RETRIG(0), .GATE_ON_KILL(1)) u_d (
        .clk(clk), .reset(reset), .go(go_d), .kill(kill_d), .kill_clr(clr_d), .done(done_d),
        .busy(busy_d), .count(count_d), .kill_ltchd(lt_d), .kill_src(src_d));

    // expected done events per DUT, encoded as cycle*16 + channel
    int exp_q [4][$];

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int dut, input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            if (d[i]) begin
                n_chk++;
                if (exp_q[dut].size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done dut%0d: got ch %0d at cycle %0d expected none", dut, i, cyc);
                end else begin
                    int e;
                    e = exp_q[dut].pop_front();
                    if (e != cyc * 16 + i) begin
                        n_fail++;
                        $display("FAIL done_event dut%0d: got cycle %0d ch %0d expected cycle %0d ch %0d",
                                 dut, cyc, i, e / 16, e % 16);
                    end
                end
            end
        end
    endtask

    // Monitor samples done pulses away from the active edge
    always @(negedge clk) begin
        mon(0, {5'd0, done_a});
        mon(1, {5'd0, done_b});
        mon(2, {5'd0, done_c});
        mon(3, done_d);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int ch_cnt7(input logic [20:0] v, input int ch);
        logic [20:0] t;
        t = v >> (ch * 7);
        return int'(t[6:0]);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int e0 [8];
        logic [31:0] exp_pack;

        tick(2);
        check("rst_count_a", count_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_ltchd_a", lt_a, 0);
        check("rst_src_a", src_a, 0);
        reset = 1'b0;
        tick(1);

        // single go on ch0
        go_a = 3'b001;
        exp_q[0].push_back((cyc + 101) * 16 + 0);
        tick(1);
        go_a = '0;
        check("t1_cnt0_start", ch_cnt7(count_a, 0), 0);
        check("t1_busy_start", busy_a, 3'b001);
        tick(99);
        check("t1_cnt0_99", ch_cnt7(count_a, 0), 99);
        tick(1);
        check("t1_cnt0_term", ch_cnt7(count_a, 0), 100);
        check("t1_done_vis", done_a, 3'b001);
        check("t1_others", count_a[20:7], 0);
        tick(1);
        check("t1_cnt0_idle", ch_cnt7(count_a, 0), 0);
        check("t1_busy_idle", busy_a, 0);
        check("t1_done_low", done_a, 0);

        // kill mid-count on ch1
        go_a = 3'b010;
        tick(1);
        go_a = '0;
        tick(40);
        check("t2_cnt1_40", ch_cnt7(count_a, 1), 40);
        kill_a = 3'b010;
        tick(1);
        kill_a = '0;
        check("t2_cnt1_killed", ch_cnt7(count_a, 1), 0);
        check("t2_busy_killed", busy_a, 0);
        check("t2_ltchd", lt_a, 1);
        check("t2_src", src_a, 3'b010);

        // gating while latched, kill beats clear, clear alone, then start
        go_a = 3'b100;
        tick(1);
        go_a = '0;
        tick(1);
        check("t3_gated_cnt2", ch_cnt7(count_a, 2), 0);
        check("t3_gated_busy", busy_a, 0);
        kill_a = 3'b001;
        clr_a = 1'b1;
        tick(1);
        kill_a = '0;
        check("t3_kill_vs_clr_lt", lt_a, 1);
        check("t3_kill_vs_clr_src", src_a, 3'b011);
        tick(1);
        clr_a = 1'b0;
        check("t3_clr_lt", lt_a, 0);
        check("t3_clr_src", src_a, 0);
        go_a = 3'b100;
        exp_q[0].push_back((cyc + 101) * 16 + 2);
        tick(1);
        go_a = '0;
        check("t3_start_busy", busy_a, 3'b100);
        tick(101);

        // retrigger (u_b) versus ignored go (u_a), identical stimulus
        go_a = 3'b001;
        go_b = 3'b001;
        exp_q[0].push_back((cyc + 101) * 16 + 0);
        tick(1);
        go_a = '0;
        go_b = '0;
        tick(60);
        check("t4_b_cnt60", ch_cnt7(count_b, 0), 60);
        go_a = 3'b001;
        go_b = 3'b001;
        exp_q[1].push_back((cyc + 101) * 16 + 0);
        tick(1);
        go_a = '0;
        go_b = '0;
        check("t4_b_retrig", ch_cnt7(count_b, 0), 0);
        check("t4_a_ignored", ch_cnt7(count_a, 0), 61);
        tick(105);

        // TERMINAL=1 sequence
        go_c = 3'b001;
        exp_q[2].push_back((cyc + 2) * 16 + 0);
        tick(1);
        go_c = '0;
        check("t5_run_cnt", count_c[1:0], 0);
        check("t5_run_busy", busy_c, 3'b001);
        tick(1);
        check("t5_done_cnt", count_c[1:0], 1);
        check("t5_done_busy", busy_c, 3'b001);
        tick(1);
        check("t5_idle_cnt", count_c[1:0], 0);
        check("t5_idle_busy", busy_c, 0);

        // kill in the DONE cycle still gives exactly one done
        go_c = 3'b010;
        exp_q[2].push_back((cyc + 2) * 16 + 1);
        tick(1);
        go_c = '0;
        tick(1);
        kill_c = 3'b010;
        tick(1);
        kill_c = '0;
        check("t5_killdone_busy", busy_c, 0);
        check("t5_killdone_src", src_c, 3'b010);
        tick(2);

        // reset mid-count
        go_a = 3'b001;
        tick(1);
        go_a = '0;
        tick(50);
        check("t6_cnt50", ch_cnt7(count_a, 0), 50);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t6_rst_count", count_a, 0);
        check("t6_rst_busy", busy_a, 0);
        check("t6_rst_done", done_a, 0);
        check("t6_rst_ltchd_c", lt_c, 0);
        check("t6_rst_src_c", src_c, 0);
        tick(105);

        // parameter sweep: 8 channels staggered by two cycles
        for (int i = 0; i < 8; i++) begin
            go_d = 8'd1 << i;
            e0[i] = cyc + 1;
            exp_q[3].push_back((cyc + 16) * 16 + i);
            tick(1);
            go_d = '0;
            tick(1);
        end
        s = cyc;
        exp_pack = '0;
        for (int i = 0; i < 8; i++) begin
            exp_pack[i*4 +: 4] = 4'(s - e0[i]);
        end
        check("t7_packing", count_d, exp_pack);
        check("t7_busy", busy_d, 8'hff);
        tick(20);
        check("t7_all_idle", busy_d, 0);

        for (int d = 0; d < 4; d++) begin
            check($sformatf("pending_done_dut%0d", d), exp_q[d].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
